serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial addition controller that time-shares one full-adder cell across all bit positions of two WIDTH-bit operands.
- The cell is two halfadd instances plus an OR gate.
- One bit is processed per clock, LSB first, under a start/busy/done handshake.
- Sits between the operand source and the result consumer; replaces a WIDTH-wide ripple adder when area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).
- CW, 5, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a result is published.
- sum  output  WIDTH  registered result; holds the last published value.
- cout  output  1  carry out of the MSB; holds the last published value.

Behaviour:
- One clock; reset is asynchronous and active-low.
- rst_n low forces state IDLE and clears busy, done, sum, cout, the carry flop, the bit counter, and the operand and result shift registers, all to 0.
- Reset asserted mid-operation aborts the addition. No done pulse is produced and sum/cout read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: load a and b into operand shift registers, carry<=0, count<=0, go to RUN.
  - With start=0: stay in IDLE.
- RUN, once per cycle:
  - Full adder computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
  - Both halfadd instances are used: ha1(a_sr[0], b_sr[0]), ha2(ha1.S, carry), carry_next = ha1.C | ha2.C.
  - res_sr <= {s, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; carry <= c; count <= count+1.
  - When count == WIDTH-1 on the current edge, go to DONE.
- DONE (exactly one cycle):
  - sum <= res_sr and cout <= carry are registered on entry, so they are visible in the DONE cycle.
  - done=1 for this cycle only.
  - Next edge returns unconditionally to IDLE.
- busy=1 exactly in RUN.
- Latency: accept edge, then WIDTH cycles busy=1, then 1 cycle done=1. The result is visible WIDTH+1 cycles after the accepting edge.
- start while busy or in DONE is ignored; it is not queued. Operand changes after the accepting edge have no effect.
- Back-to-back: start held high is re-accepted in IDLE the cycle after DONE. Minimum issue interval is WIDTH+2 cycles.
- sum/cout are not disturbed during RUN; they change only on DONE entry or reset.
- Arithmetic: {cout, sum} = a + b modulo 2^(WIDTH+1). Wrap-around at 2^WIDTH is reported via cout=1.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then a=3, b=5, start pulse → busy high 8 cycles, then done pulse; sum=8'h08, cout=0.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1; a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- a=0, b=0 → sum=0, cout=0, done after exactly WIDTH+1 cycles; a=8'hAA, b=8'h55 → sum=8'hFF, cout=0.
- Start accepted with a=1, b=1; third cycle of RUN: pulse start with a=8'h80, b=8'h80 → ignored; result sum=2, cout=0, one done pulse only.
- Start a=8'h7F, b=1; drop rst_n for half a cycle at RUN cycle 4 → busy, done, sum, cout immediately 0; no done afterwards. New start with a=2, b=2 → sum=4.
- start held high continuously with a=10, b=20 → done pulses every 10 cycles; sum=30 each time; busy low for exactly the IDLE and DONE cycles between runs.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sharing one full-adder cell across all operand bits, LSB first
//   clk, rst_n (async, active-low)
//   start, a, b : request and operands, captured on the accepting edge in IDLE
//   busy        : high while bits are being processed
//   done        : one-cycle pulse when sum/cout are published
//   sum, cout   : registered result, held until the next publish or reset
module halfadd (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_sr_q, res_sr_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d;
  logic s1, c1, s, c2, c;
  halfadd ha1 (.x(a_sr_q[0]), .y(b_sr_q[0]), .s(s1), .c(c1));
  halfadd ha2 (.x(s1), .y(carry_q), .s(s), .c(c2));
  assign c = c1 | c2;
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = {s, res_sr_q[WIDTH-1:1]};
      carry_d  = c;
      cnt_d    = cnt_q + 1'b1;
      // publish on the same edge the final bit lands, so the result is visible during DONE
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = DONE;
        sum_d   = res_sr_d;
        cout_d  = c;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: random and directed checks of serial_add_ctrl against a cycle-count transaction model
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, cout;
  int vectors = 0, miscompares = 0;
  int k = 0;
  logic [W:0] pend = '0, exp_res = '0;

  serial_add_ctrl #(.WIDTH(W), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // k = edges since the accepting edge (0 when idle); result is published W+1 edges after acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      exp_res = '0;
    end else if (k == 0) begin
      if (start) begin
        k = 1;
        pend = {1'b0, a} + {1'b0, b};
      end
    end else if (k == W + 1) begin
      k = 0;
    end else begin
      k = k + 1;
      if (k == W + 1) exp_res = pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(k >= 1 && k <= W));
      chk("done", 32'(done), 32'(k == W + 1));
      chk("sum", 32'(sum), 32'(exp_res[W-1:0]));
      chk("cout", 32'(cout), 32'(exp_res[W]));
    end
  end

  task automatic run_op(input logic [W-1:0] oa, ob, input logic [W-1:0] es, input logic ec, input int inject);
    int cnt = 0;
    @(negedge clk); #1;
    start = 1'b1; a = oa; b = ob;
    @(negedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    cnt = 1;
    while (!done && cnt < W + 6) begin
      if (cnt == inject + 1) begin
        start = 1'b1; a = 8'h80; b = 8'h80;
      end else start = 1'b0;
      @(negedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    chk("latency", 32'(cnt), 32'(W + 1));
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
  endtask

  initial begin
    int dones;
    #23 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    run_op(8'd3, 8'd5, 8'h08, 1'b0, -10);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, -10);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, -10);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, -10);
    run_op(8'hAA, 8'h55, 8'hFF, 1'b0, -10);
    run_op(8'd1, 8'd1, 8'd2, 1'b0, 3);
    @(negedge clk); #1;
    start = 1'b1; a = 8'h7F; b = 8'd1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    #4 rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    run_op(8'd2, 8'd2, 8'd4, 1'b0, -10);
    @(negedge clk); #1;
    start = 1'b1; a = 8'd10; b = 8'd20;
    dones = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (done) begin
        dones++;
        chk("b2b_sum", 32'(sum), 30);
      end
    end
    chk("b2b_dones", 32'(dones), 4);
    start = 1'b0;
    repeat (400) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
